axi_mst_ctrl_rd: RTL and testbench

// - AXI4 read-channel master (initiator). Accepts one local read request, issues one AR,

---
 rtl/axi_mst_ctrl_rd.sv | 198 +++++++++++++++++++
 tb/tb_axi_mst_ctrl_rd.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mst_ctrl_rd.sv
// AXI4 read-channel master: one local request -> one AR -> R beats streamed to the consumer.
// Optional watchdog enabled by defining AXI_MST_RD_TIMEOUT_EN (sets rd_status[4] on stall).
module axi_mst_ctrl_rd #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ID_W        = 4,
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic [LEN_W-1:0]  rd_req_len,
    input  logic [2:0]        rd_req_size,
    input  logic [1:0]        rd_req_burst,
    input  logic [ID_W-1:0]   rd_req_id,
    output logic              rd_data_valid,
    input  logic              rd_data_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_last,
    output logic              rd_done,
    output logic [4:0]        rd_status,
    output logic              axi_mst_arvalid,
    output logic [ID_W-1:0]   axi_mst_arid,
    output logic [ADDR_W-1:0] axi_mst_araddr,
    output logic [LEN_W-1:0]  axi_mst_arlen,
    output logic [2:0]        axi_mst_arsize,
    output logic [1:0]        axi_mst_arburst,
    output logic              axi_mst_arlock,
    output logic [3:0]        axi_mst_arcache,
    output logic [2:0]        axi_mst_arprot,
    output logic [3:0]        axi_mst_arqos,
    output logic [3:0]        axi_mst_arregion,
    input  logic              axi_mst_arready,
    input  logic              axi_mst_rvalid,
    input  logic [ID_W-1:0]   axi_mst_rid,
    input  logic [DATA_W-1:0] axi_mst_rdata,
    input  logic [1:0]        axi_mst_rresp,
    input  logic              axi_mst_rlast,
    output logic              axi_mst_rready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_RD   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [2:0]          size_q, size_d;
    logic [1:0]          burst_q, burst_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [1:0]          worst_q, worst_d;
    logic                id_err_q, id_err_d;
    logic                last_err_q, last_err_d;
    logic                done_q, done_d;
    logic                timeout_q;

    logic req_hs, ar_hs, r_hs, last_beat, burst_end;

    assign req_hs    = (state_q == S_IDLE) && rd_req_valid;
    assign ar_hs     = (state_q == S_AR) && axi_mst_arready;
    assign r_hs      = (state_q == S_RD) && axi_mst_rvalid && rd_data_ready;
    assign last_beat = (beat_cnt_q == len_q);
    // An early RLAST from the slave truncates the burst just like the counted last beat.
    assign burst_end = r_hs && (last_beat || axi_mst_rlast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            id_q       <= '0;
            beat_cnt_q <= '0;
            worst_q    <= '0;
            id_err_q   <= 1'b0;
            last_err_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            id_q       <= id_d;
            beat_cnt_q <= beat_cnt_d;
            worst_q    <= worst_d;
            id_err_q   <= id_err_d;
            last_err_q <= last_err_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_hs)    state_d = S_AR;
            S_AR:    if (ar_hs)     state_d = S_RD;
            S_RD:    if (burst_end) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        id_d       = id_q;
        beat_cnt_d = beat_cnt_q;
        worst_d    = worst_q;
        id_err_d   = id_err_q;
        last_err_d = last_err_q;
        done_d     = burst_end;
        if (req_hs) begin
            addr_d     = rd_req_addr;
            len_d      = rd_req_len;
            size_d     = rd_req_size;
            burst_d    = rd_req_burst;
            id_d       = rd_req_id;
            beat_cnt_d = '0;
            worst_d    = '0;
            id_err_d   = 1'b0;
            last_err_d = 1'b0;
        end
        if (r_hs) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (axi_mst_rresp > worst_q) worst_d = axi_mst_rresp;
            if (axi_mst_rid != id_q) id_err_d = 1'b1;
            if (axi_mst_rlast != last_beat) last_err_d = 1'b1;
        end
    end

`ifdef AXI_MST_RD_TIMEOUT_EN
    localparam logic [16:0] TMO_LIM = 17'(TIMEOUT_CYC);

    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_d;

    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if (req_hs) begin
            wd_cnt_d  = '0;
            timeout_d = 1'b0;
        end else if (ar_hs || r_hs) begin
            wd_cnt_d = '0;
        end else if (state_q != S_IDLE) begin
            if (wd_cnt_q != '1) wd_cnt_d = wd_cnt_q + 1'b1;
            if (({1'b0, wd_cnt_q} + 17'd1) >= TMO_LIM) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = TIMEOUT_CYC;
    assign timeout_q  = 1'b0;
`endif

    always_comb begin
        rd_req_ready    = (state_q == S_IDLE);
        axi_mst_arvalid = (state_q == S_AR);
        rd_data_valid   = (state_q == S_RD) && axi_mst_rvalid;
        axi_mst_rready  = (state_q == S_RD) && rd_data_ready;
        rd_data         = (state_q == S_RD) ? axi_mst_rdata : '0;
        rd_data_last    = (state_q == S_RD) && last_beat;
    end

    assign rd_done          = done_q;
    assign rd_status        = {timeout_q, id_err_q, last_err_q, worst_q};
    assign axi_mst_arid     = id_q;
    assign axi_mst_araddr   = addr_q;
    assign axi_mst_arlen    = len_q;
    assign axi_mst_arsize   = size_q;
    assign axi_mst_arburst  = burst_q;
    assign axi_mst_arlock   = 1'b0;
    assign axi_mst_arcache  = 4'b0011;
    assign axi_mst_arprot   = 3'b000;
    assign axi_mst_arqos    = 4'b0000;
    assign axi_mst_arregion = 4'b0000;

endmodule

// File: tb/tb_axi_mst_ctrl_rd.sv
// Directed self-checking bench for axi_mst_ctrl_rd; inputs driven on negedge, outputs checked #1 later.
module tb_axi_mst_ctrl_rd;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req_valid, rd_req_ready;
    logic [31:0] rd_req_addr;
    logic [7:0]  rd_req_len;
    logic [2:0]  rd_req_size;
    logic [1:0]  rd_req_burst;
    logic [3:0]  rd_req_id;
    logic        rd_data_valid, rd_data_ready, rd_data_last, rd_done;
    logic [31:0] rd_data;
    logic [4:0]  rd_status;
    logic        arvalid, arready, arlock;
    logic [3:0]  arid, arcache, arqos, arregion;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst;
    logic        rvalid, rlast, rready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi_mst_ctrl_rd #(
        .ADDR_W(32), .DATA_W(32), .ID_W(4), .LEN_W(8), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
        .rd_req_size(rd_req_size), .rd_req_burst(rd_req_burst), .rd_req_id(rd_req_id),
        .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
        .rd_data(rd_data), .rd_data_last(rd_data_last),
        .rd_done(rd_done), .rd_status(rd_status),
        .axi_mst_arvalid(arvalid), .axi_mst_arid(arid), .axi_mst_araddr(araddr),
        .axi_mst_arlen(arlen), .axi_mst_arsize(arsize), .axi_mst_arburst(arburst),
        .axi_mst_arlock(arlock), .axi_mst_arcache(arcache), .axi_mst_arprot(arprot),
        .axi_mst_arqos(arqos), .axi_mst_arregion(arregion), .axi_mst_arready(arready),
        .axi_mst_rvalid(rvalid), .axi_mst_rid(rid), .axi_mst_rdata(rdata),
        .axi_mst_rresp(rresp), .axi_mst_rlast(rlast), .axi_mst_rready(rready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue_req(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
        @(negedge clk);
        rd_req_valid = 1'b1; rd_req_addr = a; rd_req_len = l;
        rd_req_size = 3'd2; rd_req_burst = 2'b01; rd_req_id = id;
        #1 check("req_ready_idle", rd_req_ready, 1);
        @(negedge clk);
        rd_req_valid = 1'b0;
        #1;
        check("arvalid", arvalid, 1);
        check("araddr", araddr, a);
        check("arlen", arlen, l);
        check("arid", arid, id);
        check("arsize", arsize, 2);
        check("req_ready_ar", rd_req_ready, 0);
    endtask

    task automatic ar_accept(input int delay, input logic [31:0] a);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            arready = 1'b0;
            #1 check("ar_hold_valid", arvalid, 1);
            check("ar_hold_addr", araddr, a);
        end
        @(negedge clk);
        arready = 1'b1;
        #1 check("ar_hs_valid", arvalid, 1);
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] id, input logic [1:0] resp,
                        input logic rl, input logic exp_last);
        @(negedge clk);
        arready = 1'b0; rvalid = 1'b1; rdata = d; rid = id; rresp = resp; rlast = rl;
        rd_data_ready = 1'b1;
        #1;
        check("data_valid", rd_data_valid, 1);
        check("data", rd_data, d);
        check("data_last", rd_data_last, exp_last);
        check("rready", rready, 1);
    endtask

    task automatic stall(input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rvalid = 1'b1; rdata = d; rd_data_ready = 1'b0;
            #1 check("stall_rready", rready, 0);
            check("stall_last", rd_data_last, 0);
        end
    endtask

    task automatic finish_burst(input logic [4:0] exp_status);
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        #1;
        check("done_pulse", rd_done, 1);
        check("status", rd_status, exp_status);
        check("req_ready_done", rd_req_ready, 1);
        @(negedge clk);
        rvalid = 1'b1;
        #1;
        check("done_low", rd_done, 0);
        check("status_hold", rd_status, exp_status);
        check("idle_rready", rready, 0);
        check("idle_dvalid", rd_data_valid, 0);
        rvalid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rd_req_valid = 1'b0; rd_req_addr = '0; rd_req_len = '0;
        rd_req_size = '0; rd_req_burst = '0; rd_req_id = '0; rd_data_ready = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
        #1;
        check("rst_req_ready", rd_req_ready, 1);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_dvalid", rd_data_valid, 0);
        check("rst_last", rd_data_last, 0);
        check("rst_done", rd_done, 0);
        check("rst_status", rd_status, 0);
        check("arcache", arcache, 4'b0011);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // single beat
        issue_req(32'h100, 8'd0, 4'd2);
        ar_accept(3, 32'h100);
        beat(32'hDEADBEEF, 4'd2, 2'b00, 1'b1, 1'b1);
        finish_burst(5'b00000);

        // INCR len=3 with consumer back-pressure on beat 1
        issue_req(32'h200, 8'd3, 4'd2);
        ar_accept(0, 32'h200);
        beat(32'hA0, 4'd2, 2'b00, 1'b0, 1'b0);
        stall(32'hA1, 2);
        beat(32'hA1, 4'd2, 2'b00, 1'b0, 1'b0);
        beat(32'hA2, 4'd2, 2'b00, 1'b0, 1'b0);
        beat(32'hA3, 4'd2, 2'b00, 1'b1, 1'b1);
        finish_burst(5'b00000);

        // SLVERR on beat 2
        issue_req(32'h300, 8'd3, 4'd2);
        ar_accept(1, 32'h300);
        beat(32'hB0, 4'd2, 2'b00, 1'b0, 1'b0);
        beat(32'hB1, 4'd2, 2'b00, 1'b0, 1'b0);
        beat(32'hB2, 4'd2, 2'b10, 1'b0, 1'b0);
        beat(32'hB3, 4'd2, 2'b00, 1'b1, 1'b1);
        finish_burst(5'b00010);

        // early rlast on beat 1 of len=3
        issue_req(32'h400, 8'd3, 4'd2);
        ar_accept(0, 32'h400);
        beat(32'hC0, 4'd2, 2'b00, 1'b0, 1'b0);
        beat(32'hC1, 4'd2, 2'b00, 1'b1, 1'b0);
        finish_burst(5'b00100);

        // RID mismatch
        issue_req(32'h500, 8'd0, 4'd2);
        ar_accept(0, 32'h500);
        beat(32'hD0, 4'd5, 2'b11, 1'b1, 1'b1);
        finish_burst(5'b01011);

        // len=255 gives 256 beats, last only on the final one
        issue_req(32'h4000, 8'd255, 4'd1);
        ar_accept(0, 32'h4000);
        for (int i = 0; i < 256; i++)
            beat(32'h1000 + 32'(i), 4'd1, 2'b00, (i == 255), (i == 255));
        finish_burst(5'b00000);

        // next request accepted in the rd_done cycle, status cleared on accept
        issue_req(32'h600, 8'd0, 4'd3);
        ar_accept(0, 32'h600);
        beat(32'hE0, 4'd3, 2'b01, 1'b1, 1'b1);
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0;
        rd_req_valid = 1'b1; rd_req_addr = 32'h700; rd_req_len = 8'd3; rd_req_id = 4'd3;
        #1;
        check("b2b_done", rd_done, 1);
        check("b2b_status", rd_status, 5'b00001);
        check("b2b_req_ready", rd_req_ready, 1);
        @(negedge clk);
        rd_req_valid = 1'b0;
        #1;
        check("b2b_arvalid", arvalid, 1);
        check("b2b_araddr", araddr, 32'h700);
        check("b2b_status_clr", rd_status, 0);

        // reset mid-burst
        ar_accept(0, 32'h700);
        beat(32'hF0, 4'd3, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        rvalid = 1'b1; rst = 1'b1;
        #1;
        check("mrst_arvalid", arvalid, 0);
        check("mrst_rready", rready, 0);
        check("mrst_req_ready", rd_req_ready, 1);
        check("mrst_dvalid", rd_data_valid, 0);
        check("mrst_status", rd_status, 0);
        @(negedge clk);
        rst = 1'b0; rvalid = 1'b0;

        // long AR stall; watchdog bit stays 0 without the timeout build
        issue_req(32'h800, 8'd0, 4'd4);
        ar_accept(20, 32'h800);
        beat(32'h12345678, 4'd4, 2'b00, 1'b1, 1'b1);
`ifdef AXI_MST_RD_TIMEOUT_EN
        finish_burst(5'b10000);
`else
        finish_burst(5'b00000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
